qdec_ctx_arb: RTL and testbench

- Parametrised context-access arbiter between N CABAC syntax sub-FSMs (SAO, CQT, residual, ...) and the shared context memory / arithmetic decoder.
- Each context transaction is read-ctx → present to decoder → accept updated state → write back, serialised by round-robin.
- Generalises the fixed two-client mux with its fixed 2-cycle read delay: configurable client count and memory latency, a bypass (EP) path, and a one-entry last-written-context cache that skips the memory read on a hit.

---
 rtl/qdec_ctx_arb.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_qdec_ctx_arb.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qdec_ctx_arb.sv
// ============================================================================
// Module      : qdec_ctx_arb
// Description : Round-robin context-access arbiter between CABAC syntax
//               sub-FSMs and the shared context memory / arithmetic decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module qdec_ctx_arb #(
  parameter int N_CLIENT = 4,
  parameter int ADDR_W   = 10,
  parameter int RD_LAT   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  // context init engine
  input  logic                         init_we,
  input  logic [ADDR_W-1:0]            init_addr,
  input  logic [7:0]                   init_wdata,
  output logic                         init_rdy,
  input  logic                         flush,
  // client requests
  input  logic [N_CLIENT-1:0]          req_vld,
  input  logic [N_CLIENT*ADDR_W-1:0]   req_addr,
  input  logic [N_CLIENT-1:0]          req_ep,
  output logic [N_CLIENT-1:0]          req_rdy,
  // context memory
  output logic [ADDR_W-1:0]            ctx_addr,
  output logic                         ctx_re,
  output logic                         ctx_we,
  output logic [7:0]                   ctx_wdata,
  input  logic [7:0]                   ctx_rdata,
  // arithmetic decoder
  output logic [6:0]                   ctxState,
  output logic                         mps,
  output logic                         EPMode,
  output logic [2:0]                   grant_id,
  output logic                         ctxState_vld,
  input  logic                         ctxState_rdy,
  input  logic [7:0]                   ctxStateUpdate,
  input  logic                         ctxStateUpdate_vld,
  output logic                         ctxStateUpdate_rdy,
  // status
  output logic                         busy,
  output logic                         err_intr
);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_RD   = 2'd1;
  localparam logic [1:0] c_ST_PRES = 2'd2;
  localparam logic [1:0] c_ST_UPD  = 2'd3;

  localparam logic [2:0] c_RD_LAT  = 3'(RD_LAT);
  localparam logic [2:0] c_LAST_ID = 3'(N_CLIENT - 1);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [2:0]        r_rr_ptr;
  logic [2:0]        r_grant_id;
  logic [2:0]        r_rd_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_ep;
  logic              r_cache_vld;
  logic [ADDR_W-1:0] r_cache_addr;
  logic [7:0]        r_cache_data;
  logic              r_ctx_re;
  logic              r_ctx_we;
  logic [ADDR_W-1:0] r_ctx_addr;
  logic [7:0]        r_ctx_wdata;
  logic [7:0]        r_pres_data;
  logic              r_pres_vld;
  logic              r_ep_mode;
  logic              r_err;

  logic              w_idle;
  logic              w_found;
  logic [2:0]        w_gnt_id;
  logic [ADDR_W-1:0] w_gnt_addr;
  logic              w_gnt_ep;
  logic              w_grant;
  logic              w_init_acc;
  logic              w_hit;
  logic              w_rd_done;
  logic              w_pres_hs;
  logic              w_upd_acc;
  logic              w_err;

  // Two-pass search: clients at or above the pointer first, then wrap to 0.
  always_comb begin
    w_found    = 1'b0;
    w_gnt_id   = 3'd0;
    w_gnt_addr = '0;
    w_gnt_ep   = 1'b0;
    for (int i = 0; i < N_CLIENT; i++) begin
      if (!w_found && req_vld[i] && (i >= int'(r_rr_ptr))) begin
        w_found  = 1'b1;
        w_gnt_id = 3'(i);
      end
    end
    for (int i = 0; i < N_CLIENT; i++) begin
      if (!w_found && req_vld[i]) begin
        w_found  = 1'b1;
        w_gnt_id = 3'(i);
      end
    end
    for (int i = 0; i < N_CLIENT; i++) begin
      if (w_gnt_id == 3'(i)) begin
        w_gnt_addr = req_addr[i*ADDR_W +: ADDR_W];
        w_gnt_ep   = req_ep[i];
      end
    end
  end

  assign w_idle     = (r_state == c_ST_IDLE);
  assign w_init_acc = w_idle && init_we && !rst;
  assign w_grant    = w_idle && !init_we && w_found && !rst;
  assign w_hit      = r_cache_vld && (r_cache_addr == w_gnt_addr);
  assign w_rd_done  = (r_state == c_ST_RD) && (r_rd_cnt == c_RD_LAT);
  assign w_pres_hs  = (r_state == c_ST_PRES) && r_pres_vld && ctxState_rdy;
  assign w_upd_acc  = (r_state == c_ST_UPD) && ctxStateUpdate_vld;
  assign w_err      = !rst && ((ctxStateUpdate_vld && (r_state != c_ST_UPD)) ||
                               (ctxState_rdy && !r_pres_vld));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (w_grant) begin
          w_state_nxt = (w_gnt_ep || w_hit) ? c_ST_PRES : c_ST_RD;
        end
      end
      c_ST_RD: begin
        if (w_rd_done) begin
          w_state_nxt = c_ST_PRES;
        end
      end
      c_ST_PRES: begin
        if (w_pres_hs) begin
          w_state_nxt = r_ep ? c_ST_IDLE : c_ST_UPD;
        end
      end
      c_ST_UPD: begin
        if (w_upd_acc) begin
          w_state_nxt = c_ST_IDLE;
        end
      end
      default: w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    init_rdy           = w_init_acc;
    ctxStateUpdate_rdy = (r_state == c_ST_UPD) && !rst;
    busy               = !w_idle;
  end

  genvar gi;
  for (gi = 0; gi < N_CLIENT; gi++) begin : g_req_rdy
    assign req_rdy[gi] = w_grant && (w_gnt_id == 3'(gi));
  end

  // Transaction context and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr     <= '0;
      r_ep       <= 1'b0;
      r_grant_id <= 3'd0;
      r_rr_ptr   <= 3'd0;
    end else if (w_grant) begin
      r_addr     <= w_gnt_addr;
      r_ep       <= w_gnt_ep;
      r_grant_id <= w_gnt_id;
      r_rr_ptr   <= (w_gnt_id == c_LAST_ID) ? 3'd0 : w_gnt_id + 3'd1;
    end
  end

  // Memory strobes are single-cycle; address and data return to 0 when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctx_re    <= 1'b0;
      r_ctx_we    <= 1'b0;
      r_ctx_addr  <= '0;
      r_ctx_wdata <= 8'd0;
    end else begin
      r_ctx_re    <= 1'b0;
      r_ctx_we    <= 1'b0;
      r_ctx_addr  <= '0;
      r_ctx_wdata <= 8'd0;
      if (w_init_acc) begin
        r_ctx_we    <= 1'b1;
        r_ctx_addr  <= init_addr;
        r_ctx_wdata <= init_wdata;
      end else if (w_grant && !w_gnt_ep && !w_hit) begin
        r_ctx_re    <= 1'b1;
        r_ctx_addr  <= w_gnt_addr;
      end else if (w_upd_acc) begin
        r_ctx_we    <= 1'b1;
        r_ctx_addr  <= r_addr;
        r_ctx_wdata <= ctxStateUpdate;
      end
    end
  end

  // Read-latency counter and presentation register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_cnt    <= 3'd0;
      r_pres_data <= 8'd0;
      r_pres_vld  <= 1'b0;
      r_ep_mode   <= 1'b0;
    end else begin
      if (w_grant) begin
        r_rd_cnt <= 3'd0;
        if (w_gnt_ep) begin
          r_pres_data <= 8'd0;
          r_ep_mode   <= 1'b1;
          r_pres_vld  <= 1'b1;
        end else if (w_hit) begin
          r_pres_data <= r_cache_data;
          r_pres_vld  <= 1'b1;
        end
      end
      if (r_state == c_ST_RD) begin
        if (w_rd_done) begin
          r_pres_data <= ctx_rdata;
          r_pres_vld  <= 1'b1;
          r_rd_cnt    <= 3'd0;
        end else begin
          r_rd_cnt <= r_rd_cnt + 3'd1;
        end
      end
      if (w_pres_hs) begin
        r_pres_data <= 8'd0;
        r_pres_vld  <= 1'b0;
        r_ep_mode   <= 1'b0;
      end
    end
  end

  // Last-written-context cache; invalidation wins over a same-cycle load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cache_vld  <= 1'b0;
      r_cache_addr <= '0;
      r_cache_data <= 8'd0;
    end else begin
      if (w_upd_acc) begin
        r_cache_addr <= r_addr;
        r_cache_data <= ctxStateUpdate;
      end
      if (flush || w_init_acc) begin
        r_cache_vld <= 1'b0;
      end else if (w_upd_acc) begin
        r_cache_vld <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_err;
    end
  end

  assign ctx_addr     = r_ctx_addr;
  assign ctx_re       = r_ctx_re;
  assign ctx_we       = r_ctx_we;
  assign ctx_wdata    = r_ctx_wdata;
  assign ctxState     = r_pres_data[7:1];
  assign mps          = r_pres_data[0];
  assign EPMode       = r_ep_mode;
  assign grant_id     = r_grant_id;
  assign ctxState_vld = r_pres_vld;
  assign err_intr     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_qdec_ctx_arb.sv
// ============================================================================
// Module      : tb_qdec_ctx_arb
// Description : Scoreboard bench for qdec_ctx_arb with a latency-accurate
//               context memory model and an auto-responding decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_qdec_ctx_arb;

  localparam int N_CLIENT = 4;
  localparam int ADDR_W   = 10;
  localparam int RD_LAT   = 2;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        init_we;
  logic [ADDR_W-1:0]           init_addr;
  logic [7:0]                  init_wdata;
  logic                        init_rdy;
  logic                        flush;
  logic [N_CLIENT-1:0]         req_vld;
  logic [N_CLIENT*ADDR_W-1:0]  req_addr;
  logic [N_CLIENT-1:0]         req_ep;
  logic [N_CLIENT-1:0]         req_rdy;
  logic [ADDR_W-1:0]           ctx_addr;
  logic                        ctx_re;
  logic                        ctx_we;
  logic [7:0]                  ctx_wdata;
  logic [7:0]                  ctx_rdata;
  logic [6:0]                  ctxState;
  logic                        mps;
  logic                        EPMode;
  logic [2:0]                  grant_id;
  logic                        ctxState_vld;
  logic                        ctxState_rdy;
  logic [7:0]                  ctxStateUpdate;
  logic                        ctxStateUpdate_vld;
  logic                        ctxStateUpdate_rdy;
  logic                        busy;
  logic                        err_intr;

  // decoder behaviour knobs
  logic       rdy_auto, rdy_force, upd_auto, upd_force, mem_load;
  logic [7:0] upd_val;

  assign ctxState_rdy       = (rdy_auto & ctxState_vld) | rdy_force;
  assign ctxStateUpdate_vld = (upd_auto & ctxStateUpdate_rdy) | upd_force;
  assign ctxStateUpdate     = upd_val;

  always #5 clk = ~clk;

  qdec_ctx_arb #(.N_CLIENT(N_CLIENT), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .init_we(init_we), .init_addr(init_addr), .init_wdata(init_wdata), .init_rdy(init_rdy),
    .flush(flush),
    .req_vld(req_vld), .req_addr(req_addr), .req_ep(req_ep), .req_rdy(req_rdy),
    .ctx_addr(ctx_addr), .ctx_re(ctx_re), .ctx_we(ctx_we), .ctx_wdata(ctx_wdata),
    .ctx_rdata(ctx_rdata),
    .ctxState(ctxState), .mps(mps), .EPMode(EPMode), .grant_id(grant_id),
    .ctxState_vld(ctxState_vld), .ctxState_rdy(ctxState_rdy),
    .ctxStateUpdate(ctxStateUpdate), .ctxStateUpdate_vld(ctxStateUpdate_vld),
    .ctxStateUpdate_rdy(ctxStateUpdate_rdy),
    .busy(busy), .err_intr(err_intr)
  );

  // Context memory: data valid RD_LAT cycles after the read strobe.
  logic [7:0] mem [0:1023];
  logic [7:0] rd_pipe [RD_LAT];

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
      mem[10'h005] <= 8'h4B;
      mem[10'h010] <= 8'h20;
      mem[10'h011] <= 8'h21;
      mem[10'h012] <= 8'h22;
      mem[10'h013] <= 8'h23;
    end else if (ctx_we) begin
      mem[ctx_addr] <= ctx_wdata;
    end
    rd_pipe[0] <= ctx_re ? mem[ctx_addr] : 8'h00;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ctx_rdata = rd_pipe[RD_LAT-1];

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int g_cyc  = 0;
  int err_seen = 0;
  int bus_viol = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Expected responses: grant one-hot, {addr,lat} reads, {lat,id,ep,mps,state}, {addr,data} writes
  logic [31:0] q_gnt[$];
  logic [31:0] q_rd[$];
  logic [31:0] q_pres[$];
  logic [31:0] q_wr[$];

  initial begin : monitor
    logic vld_d;
    vld_d = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (|req_rdy) begin
          g_cyc = cyc;
          if (q_gnt.size() == 0) chk("unexpected_grant", {28'd0, req_rdy}, 32'd0);
          else chk("grant", {28'd0, req_rdy}, q_gnt.pop_front());
        end
        if (ctxState_vld && !vld_d) begin
          if (q_pres.size() == 0) chk("unexpected_pres", {31'd0, ctxState_vld}, 32'd0);
          else chk("present", {16'd0, 4'(cyc - g_cyc), grant_id, EPMode, mps, ctxState},
                   q_pres.pop_front());
        end
        if (ctx_re) begin
          if (q_rd.size() == 0) chk("unexpected_read", {31'd0, ctx_re}, 32'd0);
          else chk("read", {18'd0, ctx_addr, 4'(cyc - g_cyc)}, q_rd.pop_front());
        end
        if (ctx_we) begin
          if (q_wr.size() == 0) chk("unexpected_write", {31'd0, ctx_we}, 32'd0);
          else chk("write", {14'd0, ctx_addr, ctx_wdata}, q_wr.pop_front());
        end
        if (err_intr) err_seen++;
        if (!ctx_re && !ctx_we && ((ctx_addr != '0) || (ctx_wdata != 8'd0))) bus_viol++;
      end
      vld_d = ctxState_vld;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int c, input logic [ADDR_W-1:0] a, input logic ep);
    req_vld[c] = 1'b1;
    req_addr[c*ADDR_W +: ADDR_W] = a;
    req_ep[c] = ep;
  endtask

  task automatic wait_grant(input int c);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (req_rdy[c]) seen = 1'b1;
    end
    if (!seen) chk("grant_timeout", {31'd0, req_rdy[c]}, 32'd1);
  endtask

  task automatic wait_idle();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (!busy) seen = 1'b1;
    end
    if (!seen) chk("idle_timeout", {31'd0, busy}, 32'd0);
    tick();
    tick();
  endtask

  task automatic do_req(input int c, input logic [ADDR_W-1:0] a, input logic ep);
    tick();
    set_req(c, a, ep);
    wait_grant(c);
    tick();
    req_vld[c] = 1'b0;
    req_ep[c]  = 1'b0;
    wait_idle();
  endtask

  task automatic check_reset(input string tag);
    @(negedge clk);
    chk({tag, "_ctl"}, {20'd0, init_rdy, req_rdy, ctx_re, ctx_we, ctxState_vld,
        ctxStateUpdate_rdy, busy, err_intr, EPMode, mps, grant_id}, 32'd0);
    chk({tag, "_data"}, {7'd0, ctx_addr, ctx_wdata, ctxState}, 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
    $fatal(1);
  end

  initial begin : stimulus
    int ngr;
    rst = 1'b1; mem_load = 1'b1;
    init_we = 1'b0; init_addr = '0; init_wdata = 8'd0; flush = 1'b0;
    req_vld = '0; req_addr = '0; req_ep = '0;
    rdy_auto = 1'b1; rdy_force = 1'b0; upd_auto = 1'b1; upd_force = 1'b0; upd_val = 8'd0;
    repeat (3) tick();
    rst = 1'b0; mem_load = 1'b0;
    check_reset("reset");

    // miss: 0x4B -> state 0x25 mps 1 at T+4, writeback 0x4D
    upd_val = 8'h4D;
    q_gnt.push_back(32'b0010);
    q_rd.push_back({18'd0, 10'h005, 4'd1});
    q_pres.push_back({16'd0, 4'd4, 3'd1, 1'b0, 1'b1, 7'h25});
    q_wr.push_back({14'd0, 10'h005, 8'h4D});
    do_req(1, 10'h005, 1'b0);

    // hit on the cached 0x4D -> state 0x26 mps 1 at T+1, no read
    upd_val = 8'h51;
    q_gnt.push_back(32'b0010);
    q_pres.push_back({16'd0, 4'd1, 3'd1, 1'b0, 1'b1, 7'h26});
    q_wr.push_back({14'd0, 10'h005, 8'h51});
    do_req(1, 10'h005, 1'b0);

    // reset while in RD: transaction abandoned, no writeback
    q_gnt.push_back(32'b0001);
    q_rd.push_back({18'd0, 10'h012, 4'd1});
    tick();
    set_req(0, 10'h012, 1'b0);
    wait_grant(0);
    tick();
    req_vld[0] = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset("reset_in_rd");
    tick();

    // cache cleared by reset: 0x05 must miss and read 0x51
    q_gnt.push_back(32'b1000);
    q_rd.push_back({18'd0, 10'h005, 4'd1});
    q_pres.push_back({16'd0, 4'd4, 3'd3, 1'b0, 1'b1, 7'h28});
    q_wr.push_back({14'd0, 10'h005, 8'h51});
    do_req(3, 10'h005, 1'b0);

    // round robin from pointer 0, all clients requesting
    upd_val = 8'h33;
    q_gnt.push_back(32'b0001); q_gnt.push_back(32'b0010); q_gnt.push_back(32'b0100);
    q_gnt.push_back(32'b1000); q_gnt.push_back(32'b0001);
    q_rd.push_back({18'd0, 10'h010, 4'd1}); q_rd.push_back({18'd0, 10'h011, 4'd1});
    q_rd.push_back({18'd0, 10'h012, 4'd1}); q_rd.push_back({18'd0, 10'h013, 4'd1});
    q_rd.push_back({18'd0, 10'h010, 4'd1});
    q_pres.push_back({16'd0, 4'd4, 3'd0, 1'b0, 1'b0, 7'h10});
    q_pres.push_back({16'd0, 4'd4, 3'd1, 1'b0, 1'b1, 7'h10});
    q_pres.push_back({16'd0, 4'd4, 3'd2, 1'b0, 1'b0, 7'h11});
    q_pres.push_back({16'd0, 4'd4, 3'd3, 1'b0, 1'b1, 7'h11});
    q_pres.push_back({16'd0, 4'd4, 3'd0, 1'b0, 1'b1, 7'h19});
    q_wr.push_back({14'd0, 10'h010, 8'h33}); q_wr.push_back({14'd0, 10'h011, 8'h33});
    q_wr.push_back({14'd0, 10'h012, 8'h33}); q_wr.push_back({14'd0, 10'h013, 8'h33});
    q_wr.push_back({14'd0, 10'h010, 8'h33});
    tick();
    for (int c = 0; c < N_CLIENT; c++) set_req(c, 10'(16 + c), 1'b0);
    ngr = 0;
    for (int k = 0; k < 400 && ngr < 5; k++) begin
      @(negedge clk);
      if (|req_rdy) ngr++;
    end
    chk("rr_grant_count", ngr, 32'd5);
    tick();
    req_vld = '0;
    wait_idle();

    // EP bypass on client 2: state 0, EPMode 1 at T+1, no memory traffic
    q_gnt.push_back(32'b0100);
    q_pres.push_back({16'd0, 4'd1, 3'd2, 1'b1, 1'b0, 7'h00});
    do_req(2, 10'h3FF, 1'b1);

    // init write beats a same-cycle request; flush during UPD keeps the writeback
    upd_val  = 8'h77;
    upd_auto = 1'b0;
    q_wr.push_back({14'd0, 10'h005, 8'h10});
    q_gnt.push_back(32'b0010);
    q_rd.push_back({18'd0, 10'h005, 4'd1});
    q_pres.push_back({16'd0, 4'd4, 3'd1, 1'b0, 1'b0, 7'h08});
    q_wr.push_back({14'd0, 10'h005, 8'h77});
    tick();
    init_we = 1'b1; init_addr = 10'h005; init_wdata = 8'h10;
    set_req(1, 10'h005, 1'b0);
    @(negedge clk);
    chk("init_rdy", {31'd0, init_rdy}, 32'd1);
    chk("init_blocks_grant", {28'd0, req_rdy}, 32'd0);
    tick();
    init_we = 1'b0; init_addr = '0; init_wdata = 8'd0;
    wait_grant(1);
    tick();
    req_vld[1] = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
        @(negedge clk);
        if (ctxStateUpdate_rdy) seen = 1'b1;
      end
      if (!seen) chk("upd_rdy_timeout", {31'd0, ctxStateUpdate_rdy}, 32'd1);
    end
    flush = 1'b1;
    tick();
    upd_auto = 1'b1;
    tick();
    flush = 1'b0;
    wait_idle();

    // flush beat the cache load, so 0x05 misses and reads 0x77
    q_gnt.push_back(32'b0010);
    q_rd.push_back({18'd0, 10'h005, 4'd1});
    q_pres.push_back({16'd0, 4'd4, 3'd1, 1'b0, 1'b1, 7'h3B});
    q_wr.push_back({14'd0, 10'h005, 8'h77});
    do_req(1, 10'h005, 1'b0);

    // protocol errors in IDLE
    tick();
    upd_force = 1'b1;
    tick();
    upd_force = 1'b0;
    repeat (2) tick();
    rdy_force = 1'b1;
    tick();
    rdy_force = 1'b0;
    repeat (5) tick();

    chk("err_pulses", err_seen, 32'd2);
    chk("bus_idle_zero", bus_viol, 32'd0);
    chk("pending_grants", q_gnt.size(), 32'd0);
    chk("pending_reads", q_rd.size(), 32'd0);
    chk("pending_pres", q_pres.size(), 32'd0);
    chk("pending_writes", q_wr.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
